regfile_sb: RTL and testbench

- Parametrised successor to the single-issue NPC integer register file.
- Generalised to N read ports and M write ports, with write-to-read bypass and x0 hardwired to zero.
- Adds a per-register busy scoreboard for the pipelined core: decode queries hazards, issue marks a destination pending, writeback clears it, flush drops all pending state.
- Sits between the ID stage (reads, issue) and the WB stage (writes); a debug read port feeds difftest.

---
 rtl/regfile_sb_pkg.sv | 12 +
 rtl/regfile_sb_rf_bypass_mux.sv | 35 +++
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared configuration for the NPC register-file slice.
// Provides default widths/sizes and the hardwired-zero register address.
package regfile_sb_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned REG_NUM_BIT_DEF = 5;
    localparam int unsigned REG_NUM_DEF     = 2 ** REG_NUM_BIT_DEF;

    // Architectural x0: reads as zero, writes discarded, never busy.
    localparam logic [REG_NUM_BIT_DEF-1:0] X0 = '0;

endpackage

// File: rtl/regfile_sb_rf_bypass_mux.sv
// One read port's data selection.
// Ports:
//   raddr   - read address of this port
//   rf_word - architectural value rf[raddr]
//   wen/waddr/wdata - flattened write-port bundle (port i at slice i)
//   rdata   - 0 for x0, else bypassed write data (highest port wins), else rf_word
module rf_bypass_mux
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned REG_NUM_BIT = REG_NUM_BIT_DEF,
    parameter int unsigned WRITE_PORTS = 2
) (
    input  logic [REG_NUM_BIT-1:0]             raddr,
    input  logic [DATA_WIDTH-1:0]              rf_word,
    input  logic [WRITE_PORTS-1:0]             wen,
    input  logic [WRITE_PORTS*REG_NUM_BIT-1:0] waddr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]              rdata
);

    always_comb begin
        rdata = rf_word;
        // Ascending scan so the highest-indexed matching port is applied last.
        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
            if (wen[i] && (waddr[i*REG_NUM_BIT +: REG_NUM_BIT] == raddr)) begin
                rdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (raddr == REG_NUM_BIT'(X0)) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass and a
// per-register busy scoreboard.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   raddr/rdata/rhazard - READ_PORTS packed read ports and hazard flags
//   wen/waddr/wdata     - WRITE_PORTS packed write ports (highest index wins)
//   issue_valid/issue_rd/issue_ready - mark a destination register pending
//   flush               - drop all pending state
//   dbg_addr/dbg_data   - architectural (unbypassed) read for difftest
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned REG_NUM     = REG_NUM_DEF,
    parameter int unsigned REG_NUM_BIT = REG_NUM_BIT_DEF,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [READ_PORTS*REG_NUM_BIT-1:0]  raddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]   rdata,
    output logic [READ_PORTS-1:0]              rhazard,
    input  logic [WRITE_PORTS-1:0]             wen,
    input  logic [WRITE_PORTS*REG_NUM_BIT-1:0] waddr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]  wdata,
    input  logic                               issue_valid,
    input  logic [REG_NUM_BIT-1:0]             issue_rd,
    output logic                               issue_ready,
    input  logic                               flush,
    input  logic [REG_NUM_BIT-1:0]             dbg_addr,
    output logic [DATA_WIDTH-1:0]              dbg_data
);

    logic [DATA_WIDTH-1:0] rf_q [REG_NUM];
    logic [DATA_WIDTH-1:0] rf_d [REG_NUM];
    logic [REG_NUM-1:0]    busy_q;
    logic [REG_NUM-1:0]    busy_d;
    logic [REG_NUM-1:0]    wr_hit;
    logic                  issue_acc;

    // Register-file next state and per-register write-hit decode.
    always_comb begin
        rf_d   = rf_q;
        wr_hit = '0;
        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
            if (wen[i]) begin
                rf_d[waddr[i*REG_NUM_BIT +: REG_NUM_BIT]]   = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                wr_hit[waddr[i*REG_NUM_BIT +: REG_NUM_BIT]] = 1'b1;
            end
        end
        rf_d[0]   = '0;
        wr_hit[0] = 1'b0;
    end

    // A busy destination may be reissued in the cycle its writer retires.
    assign issue_ready = ~flush & ((issue_rd == REG_NUM_BIT'(X0)) | ~busy_q[issue_rd] | wr_hit[issue_rd]);
    assign issue_acc   = issue_valid & issue_ready;

    // Set after clear: a newly issued writer stays pending past the retiring one.
    always_comb begin
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~wr_hit;
            if (issue_acc) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < READ_PORTS; j++) begin : g_rd
        logic [REG_NUM_BIT-1:0] ra;
        assign ra = raddr[j*REG_NUM_BIT +: REG_NUM_BIT];

        rf_bypass_mux #(
            .DATA_WIDTH  (DATA_WIDTH),
            .REG_NUM_BIT (REG_NUM_BIT),
            .WRITE_PORTS (WRITE_PORTS)
        ) u_mux (
            .raddr   (ra),
            .rf_word (rf_q[ra]),
            .wen     (wen),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[j*DATA_WIDTH +: DATA_WIDTH])
        );

        assign rhazard[j] = busy_q[ra] & ~wr_hit[ra];
    end

    assign dbg_data = (dbg_addr == REG_NUM_BIT'(X0)) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rhazard;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_WIDTH  (32),
        .REG_NUM     (32),
        .REG_NUM_BIT (5),
        .READ_PORTS  (2),
        .WRITE_PORTS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr       (raddr),
        .rdata       (rdata),
        .rhazard     (rhazard),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge, then leave time for inputs to be changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a0);
        raddr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a0, input logic [31:0] d0);
        wen   = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic no_wr();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; raddr = '0; no_wr();
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; dbg_addr = '0;
        tick();
        rst_n = 1'b1;

        // Reset state
        set_rd(5'd5, 5'd0); dbg_addr = 5'd5; settle();
        check("rst_rdata0", rdata[31:0], 32'h0);
        check("rst_rdata1", rdata[63:32], 32'h0);
        check("rst_rhazard", {30'd0, rhazard}, 32'h0);
        check("rst_issue_ready", {31'd0, issue_ready}, 32'h1);
        check("rst_dbg", dbg_data, 32'h0);

        // Write then read; debug port is not bypassed during the write
        set_wr(2'b01, 5'd0, 32'h0, 5'd15, 32'hDEADBEEF); dbg_addr = 5'd15; settle();
        check("dbg_no_bypass", dbg_data, 32'h0);
        tick(); no_wr();
        set_rd(5'd0, 5'd15); settle();
        check("wr_rd_rdata0", rdata[31:0], 32'hDEADBEEF);
        check("wr_rd_dbg", dbg_data, 32'hDEADBEEF);

        // Bypass with same-address priority
        set_wr(2'b11, 5'd7, 32'h22, 5'd7, 32'h11); set_rd(5'd7, 5'd7); settle();
        check("byp_prio_rdata0", rdata[31:0], 32'h22);
        check("byp_prio_rdata1", rdata[63:32], 32'h22);
        tick(); no_wr(); dbg_addr = 5'd7; settle();
        check("prio_stored_rdata0", rdata[31:0], 32'h22);
        check("prio_stored_dbg", dbg_data, 32'h22);

        // Writes to x0 discarded
        set_wr(2'b11, 5'd0, 32'h55, 5'd0, 32'h55); set_rd(5'd0, 5'd0); settle();
        check("x0_bypass", rdata[31:0], 32'h0);
        tick(); no_wr(); dbg_addr = 5'd0; settle();
        check("x0_stored_rdata1", rdata[63:32], 32'h0);
        check("x0_dbg", dbg_data, 32'h0);

        // Two ports writing different registers, crossed reads
        set_wr(2'b11, 5'd21, 32'hB1, 5'd20, 32'hA0); set_rd(5'd20, 5'd21); settle();
        check("dual_byp_rdata0", rdata[31:0], 32'hB1);
        check("dual_byp_rdata1", rdata[63:32], 32'hA0);
        tick(); no_wr(); settle();
        check("dual_st_rdata0", rdata[31:0], 32'hB1);
        check("dual_st_rdata1", rdata[63:32], 32'hA0);

        // Scoreboard hazard
        issue_valid = 1'b1; issue_rd = 5'd10; settle();
        check("sb_issue_ready", {31'd0, issue_ready}, 32'h1);
        tick(); issue_valid = 1'b0;
        set_rd(5'd10, 5'd10); settle();
        check("sb_rhazard_busy", {30'd0, rhazard}, 32'h3);
        issue_valid = 1'b1; settle();
        check("sb_waw_block", {31'd0, issue_ready}, 32'h0);
        tick(); issue_valid = 1'b0; settle();
        check("sb_still_busy", {30'd0, rhazard}, 32'h3);
        set_wr(2'b01, 5'd0, 32'h0, 5'd10, 32'h5); settle();
        check("sb_wb_rhazard", {30'd0, rhazard}, 32'h0);
        check("sb_wb_rdata1", rdata[63:32], 32'h5);
        check("sb_wb_ready", {31'd0, issue_ready}, 32'h1);
        tick(); no_wr(); settle();
        check("sb_cleared", {30'd0, rhazard}, 32'h0);
        check("sb_cleared_rdata", rdata[31:0], 32'h5);

        // Set/clear collision on reg 3
        issue_valid = 1'b1; issue_rd = 5'd3; tick();
        set_wr(2'b01, 5'd0, 32'h0, 5'd3, 32'h333); settle();
        check("coll_ready", {31'd0, issue_ready}, 32'h1);
        tick(); no_wr(); issue_valid = 1'b0;
        set_rd(5'd0, 5'd3); settle();
        check("coll_busy", {30'd0, rhazard}, 32'h1);
        check("coll_rdata", rdata[31:0], 32'h333);

        // Flush
        issue_valid = 1'b1; issue_rd = 5'd4; tick();
        issue_rd = 5'd9; tick();
        issue_valid = 1'b0; set_rd(5'd9, 5'd4); settle();
        check("fl_pre_busy", {30'd0, rhazard}, 32'h3);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12; settle();
        check("fl_issue_blocked", {31'd0, issue_ready}, 32'h0);
        tick(); flush = 1'b0; issue_valid = 1'b0;
        settle();
        check("fl_busy_cleared", {30'd0, rhazard}, 32'h0);
        set_rd(5'd3, 5'd12); settle();
        check("fl_no_12_and_3", {30'd0, rhazard}, 32'h0);

        // Reset mid-operation beats write and issue
        issue_valid = 1'b1; issue_rd = 5'd6; tick();
        set_rd(5'd6, 5'd6); settle();
        check("rst_mid_pre", {30'd0, rhazard}, 32'h3);
        set_wr(2'b01, 5'd0, 32'h0, 5'd25, 32'hFFFF); issue_rd = 5'd25; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; no_wr(); issue_valid = 1'b0;
        set_rd(5'd6, 5'd25); dbg_addr = 5'd15; settle();
        check("rst_mid_rdata0", rdata[31:0], 32'h0);
        check("rst_mid_rhazard", {30'd0, rhazard}, 32'h0);
        check("rst_mid_dbg15", dbg_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
